// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 16x oversampling UART receiver with parity/stop checks and valid/ready output
module uart_rx #(
  parameter int DATA_WIDTH  = 8,
  parameter int PARITY_EN   = 0,
  parameter int PARITY_ODD  = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  baud_en_i,
  input  logic                  rx_i,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  input  logic                  rx_ready_i,
  output logic                  frame_err_o,
  output logic                  parity_err_o,
  output logic                  overrun_err_o,
  output logic                  busy_o
);

  localparam logic       HAS_PAR  = (PARITY_EN != 0);
  localparam logic       ODD      = (PARITY_ODD != 0);
  localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [3:0]              bit_q, bit_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic                    perr_q, perr_d;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    rx_s;

  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    fe_q, fe_d;
  logic                    pe_q, pe_d;
  logic                    ovr_q, ovr_d;
  logic                    complete;

  // Synchroniser resets to the idle line level so reset never looks like a start bit
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      perr_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      pe_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      perr_q  <= perr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      pe_q    <= pe_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    perr_d   = perr_q;
    complete = 1'b0;

    if (baud_en_i) begin
      cnt_d = cnt_q + 4'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (baud_en_i && !rx_s) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (baud_en_i && cnt_q == 4'd7) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            bit_d   = '0;
            perr_d  = 1'b0;
          end
        end
      end
      S_DATA: begin
        // Counter==15 lands at mid-bit because START handed over at mid start bit
        if (baud_en_i && cnt_q == 4'd15) begin
          shift_d = {rx_s, shift_q[DATA_WIDTH-1:1]};
          bit_d   = bit_q + 4'd1;
          if (bit_q == LAST_BIT) begin
            state_d = HAS_PAR ? S_PARITY : S_STOP;
            cnt_d   = '0;
          end
        end
      end
      S_PARITY: begin
        if (baud_en_i && cnt_q == 4'd15) begin
          perr_d  = ((^shift_q) ^ rx_s) != ODD;
          state_d = S_STOP;
          cnt_d   = '0;
        end
      end
      S_STOP: begin
        if (baud_en_i && cnt_q == 4'd15) begin
          complete = 1'b1;
          state_d  = rx_s ? S_IDLE : S_BREAK;
          cnt_d    = '0;
        end
      end
      S_BREAK: begin
        if (baud_en_i && rx_s) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output register: a completed word is dropped (with overrun pulse) if the previous one is still pending
  always_comb begin
    data_d  = data_q;
    fe_d    = fe_q;
    pe_d    = pe_q;
    valid_d = valid_q & ~rx_ready_i;
    ovr_d   = 1'b0;
    if (complete) begin
      if (!valid_q || rx_ready_i) begin
        data_d  = shift_q;
        fe_d    = ~rx_s;
        pe_d    = perr_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  assign rx_data_o     = data_q;
  assign rx_valid_o    = valid_q;
  assign frame_err_o   = fe_q;
  assign parity_err_o  = pe_q;
  assign overrun_err_o = ovr_q;
  assign busy_o        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx (8N1 and 8E1 instances)
module tb_uart_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic baud_en = 1'b0;
  logic rx0 = 1'b1, rx1 = 1'b1;
  logic rdy0 = 1'b1, rdy1 = 1'b1;

  logic [7:0] d0, d1;
  logic v0, v1, fe0, fe1, pe0, pe1, ovr0, ovr1, busy0, busy1;

  typedef struct packed {
    logic [7:0] data;
    logic       fe;
    logic       pe;
  } word_t;

  word_t q0[$];
  word_t q1[$];
  word_t e0, e1;

  int checks = 0;
  int failures = 0;
  int vcyc0 = 0;
  int ovr_cnt0 = 0;
  int ovr_base;
  int bcnt = 0;

  uart_rx #(.DATA_WIDTH(8), .PARITY_EN(0), .PARITY_ODD(0), .SYNC_STAGES(2)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .baud_en_i(baud_en), .rx_i(rx0),
    .rx_data_o(d0), .rx_valid_o(v0), .rx_ready_i(rdy0),
    .frame_err_o(fe0), .parity_err_o(pe0), .overrun_err_o(ovr0), .busy_o(busy0)
  );

  uart_rx #(.DATA_WIDTH(8), .PARITY_EN(1), .PARITY_ODD(0), .SYNC_STAGES(2)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .baud_en_i(baud_en), .rx_i(rx1),
    .rx_data_o(d1), .rx_valid_o(v1), .rx_ready_i(rdy1),
    .frame_err_o(fe1), .parity_err_o(pe1), .overrun_err_o(ovr1), .busy_o(busy1)
  );

  // One tick every 4 clocks
  always @(negedge clk) begin
    bcnt = (bcnt + 1) % 4;
    baud_en = (bcnt == 0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (v0) vcyc0++;
      if (ovr0) ovr_cnt0++;
      if (v0 && rdy0) begin
        chk("sb0_nonempty", 32'(q0.size() != 0), 32'd1);
        if (q0.size() != 0) begin
          e0 = q0.pop_front();
          chk("sb0_data", 32'(d0), 32'(e0.data));
          chk("sb0_frame_err", 32'(fe0), 32'(e0.fe));
          chk("sb0_parity_err", 32'(pe0), 32'(e0.pe));
        end
      end
      if (v1 && rdy1) begin
        chk("sb1_nonempty", 32'(q1.size() != 0), 32'd1);
        if (q1.size() != 0) begin
          e1 = q1.pop_front();
          chk("sb1_data", 32'(d1), 32'(e1.data));
          chk("sb1_frame_err", 32'(fe1), 32'(e1.fe));
          chk("sb1_parity_err", 32'(pe1), 32'(e1.pe));
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_rx(input int ch, input logic b);
    if (ch == 0) rx0 = b;
    else         rx1 = b;
  endtask

  // Drives a full frame, 64 clocks per bit; the line is left at the stop-bit level
  task automatic send(input int ch, input logic [7:0] d, input logic has_par,
                      input logic par, input logic stop);
    set_rx(ch, 1'b0);
    step(64);
    for (int i = 0; i < 8; i++) begin
      set_rx(ch, d[i]);
      step(64);
    end
    if (has_par) begin
      set_rx(ch, par);
      step(64);
    end
    set_rx(ch, stop);
    step(64);
  endtask

  initial begin
    step(3);
    chk("reset_valid", 32'(v0), 32'd0);
    chk("reset_data", 32'(d0), 32'd0);
    chk("reset_busy", 32'(busy0), 32'd0);
    chk("reset_flags", 32'({fe0, pe0, ovr0}), 32'd0);
    rst_n = 1'b1;
    step(10);

    // Clean 8N1 frame
    vcyc0 = 0;
    q0.push_back('{8'hA5, 1'b0, 1'b0});
    send(0, 8'hA5, 1'b0, 1'b0, 1'b1);
    step(4);
    chk("t1_valid_cycles", 32'(vcyc0), 32'd1);
    chk("t1_busy_after", 32'(busy0), 32'd0);
    chk("t1_sb_drained", 32'(q0.size()), 32'd0);

    // Glitch shorter than half a bit
    rx0 = 1'b0;
    step(12);
    rx0 = 1'b1;
    step(1);
    chk("t2_busy_during", 32'(busy0), 32'd1);
    step(64);
    chk("t2_busy_after", 32'(busy0), 32'd0);
    chk("t2_no_word", 32'(vcyc0), 32'd1);
    q0.push_back('{8'h3C, 1'b0, 1'b0});
    send(0, 8'h3C, 1'b0, 1'b0, 1'b1);
    step(4);
    chk("t2_sb_drained", 32'(q0.size()), 32'd0);

    // Framing error followed by a held-low break
    q0.push_back('{8'h3C, 1'b1, 1'b0});
    send(0, 8'h3C, 1'b0, 1'b0, 1'b0);
    step(160);
    chk("t3_break_busy", 32'(busy0), 32'd1);
    chk("t3_one_word", 32'(vcyc0), 32'd3);
    rx0 = 1'b1;
    step(64);
    chk("t3_idle_after_break", 32'(busy0), 32'd0);
    q0.push_back('{8'h81, 1'b0, 1'b0});
    send(0, 8'h81, 1'b0, 1'b0, 1'b1);
    step(4);
    chk("t3_sb_drained", 32'(q0.size()), 32'd0);

    // Overrun: second word discarded while the first is pending
    rdy0 = 1'b0;
    ovr_base = ovr_cnt0;
    q0.push_back('{8'h11, 1'b0, 1'b0});
    send(0, 8'h11, 1'b0, 1'b0, 1'b1);
    send(0, 8'h22, 1'b0, 1'b0, 1'b1);
    step(4);
    chk("t4_valid_held", 32'(v0), 32'd1);
    chk("t4_data_held", 32'(d0), 32'h11);
    chk("t4_overrun_pulses", 32'(ovr_cnt0 - ovr_base), 32'd1);
    rdy0 = 1'b1;
    step(2);
    chk("t4_valid_dropped", 32'(v0), 32'd0);
    chk("t4_sb_drained", 32'(q0.size()), 32'd0);

    // Even parity on the second instance
    q1.push_back('{8'h07, 1'b0, 1'b1});
    send(1, 8'h07, 1'b1, 1'b0, 1'b1);
    q1.push_back('{8'h07, 1'b0, 1'b0});
    send(1, 8'h07, 1'b1, 1'b1, 1'b1);
    step(4);
    chk("t5_sb_drained", 32'(q1.size()), 32'd0);

    // Reset during data bit 3 of 0xFF
    rx0 = 1'b0;
    step(64);
    rx0 = 1'b1;
    step(64 * 3 + 32);
    chk("t6_busy_before_reset", 32'(busy0), 32'd1);
    rst_n = 1'b0;
    step(1);
    chk("t6_reset_busy", 32'(busy0), 32'd0);
    chk("t6_reset_outputs", 32'({v0, fe0, pe0, ovr0}), 32'd0);
    chk("t6_reset_data", 32'(d0), 32'd0);
    rst_n = 1'b1;
    step(64 * 8);
    chk("t6_no_partial_word", 32'(v0), 32'd0);
    q0.push_back('{8'h5A, 1'b0, 1'b0});
    send(0, 8'h5A, 1'b0, 1'b0, 1'b1);
    step(4);
    chk("t6_sb_drained", 32'(q0.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
